icache_assoc: RTL and testbench

Parametrised N-way set-associative, read-only instruction cache between the CPU fetch port and the 128-bit line memory.
- Generalises the fixed 2-way, 8-set instruction cache in three ways: set count and way count are parameters, and the replacement policy is selectable.
- Adds two behaviours the earlier cache lacks: a whole-cache flush, and saturating hit/miss counters.
- A miss costs the memory latency plus one lookup cycle.

---
 rtl/icache_assoc_if.sv | 28 ++
 rtl/icache_assoc.sv | 199 +++++++++++++++++++
 tb/tb_icache_assoc.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_if.sv
// Fetch-port and line-memory signal bundle for icache_assoc.
// slave  : cache side (takes fetch requests, issues line fills)
// master : environment side (CPU fetch unit plus line memory)
// Signals: proc_read/proc_addr/proc_flush -> cache, proc_rdata/proc_stall <- cache,
//          mem_read/mem_write/mem_addr/mem_wdata <- cache, mem_rdata/mem_ready -> cache.
interface icache_assoc_if;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic         proc_flush;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_addr, proc_flush, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_addr, proc_flush, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/icache_assoc.sv
// Parametrised N-way set-associative read-only instruction cache.
// Hits return the word combinationally in the request cycle; a miss fetches a
// 128-bit line and replays as a hit once the line is installed.
// Ports: clk, proc_reset_n (synchronous, active low), bus (icache_assoc_if.slave),
//        hit_cnt / miss_cnt (saturating performance counters).
module icache_assoc #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned REPL  = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset_n,
    icache_assoc_if.slave    bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 28 - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);
    localparam bit USE_LRU = (REPL == 0) || (WAYS == 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state_q, state_d;
    logic   flush_pend_q;
    logic   mem_read_q;
    logic [27:0] mem_addr_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [127:0]     line_q  [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [IDX_W-1:0] req_idx, fill_idx, touch_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c, victim_c, touch_way;
    logic [127:0]     hit_line_c;
    logic             touch_en;
    logic             stall_c;
    logic [31:0]      rdata_c;
    logic             do_flush, do_hit, do_miss, do_fill;

    // Request decode uses the live address; fills use the latched miss address.
    assign req_idx  = bus.proc_addr[IDX_W+1:2];
    assign req_tag  = bus.proc_addr[29:IDX_W+2];
    assign fill_idx = mem_addr_q[IDX_W-1:0];
    assign fill_tag = mem_addr_q[27:IDX_W];

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!hit_c && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        hit_line_c = line_q[req_idx][hit_way_c];
    end

    // Victim: lowest invalid way first, then oldest age or round-robin pointer.
    always_comb begin
        logic found;
        found    = 1'b0;
        victim_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!found && !valid_q[fill_idx][w]) begin
                found    = 1'b1;
                victim_c = WAY_W'(w);
            end
        end
        if (!found) begin
            if (USE_LRU) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (age_q[fill_idx][w] == OLDEST) victim_c = WAY_W'(w);
                end
            end else begin
                victim_c = rr_q[fill_idx];
            end
        end
    end

    // Hits and fills are mutually exclusive, so they share one age-update port.
    assign touch_en  = USE_LRU && (do_hit || do_fill);
    assign touch_idx = do_fill ? fill_idx : req_idx;
    assign touch_way = do_fill ? victim_c : hit_way_c;

    // Next-state and fetch-port outputs.
    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b0;
        rdata_c  = '0;
        do_flush = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_fill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.proc_flush || flush_pend_q) begin
                    do_flush = 1'b1;
                    stall_c  = 1'b1;
                end else if (bus.proc_read) begin
                    if (hit_c) begin
                        do_hit  = 1'b1;
                        rdata_c = hit_line_c[{bus.proc_addr[1:0], 5'd0} +: 32];
                    end else begin
                        do_miss = 1'b1;
                        stall_c = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                stall_c = 1'b1;
                if (bus.mem_ready) begin
                    do_fill = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!proc_reset_n) begin
            stall_c = 1'b0;
            rdata_c = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) state_q <= IDLE;
        else               state_q <= state_d;
    end

    // Valid bits, replacement state, fill handshake and counters.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            flush_pend_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < int'(WAYS); w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            if (state_q == FETCH && bus.proc_flush) flush_pend_q <= 1'b1;
            if (do_flush) begin
                flush_pend_q <= 1'b0;
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                    for (int w = 0; w < int'(WAYS); w++) age_q[s][w] <= WAY_W'(w);
                end
            end
            if (do_hit && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + CNT_W'(1);
            if (do_miss) begin
                if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
                mem_read_q <= 1'b1;
                mem_addr_q <= bus.proc_addr[29:2];
            end
            if (do_fill) begin
                mem_read_q                  <= 1'b0;
                valid_q[fill_idx][victim_c] <= 1'b1;
                if (!USE_LRU) rr_q[fill_idx] <= rr_q[fill_idx] + WAY_W'(1);
            end
            // Ways younger than the touched way age by one; the touched way becomes 0.
            if (touch_en) begin
                for (int v = 0; v < int'(WAYS); v++) begin
                    if (WAY_W'(v) == touch_way)
                        age_q[touch_idx][v] <= '0;
                    else if (age_q[touch_idx][v] < age_q[touch_idx][touch_way])
                        age_q[touch_idx][v] <= age_q[touch_idx][v] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and line storage; contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (proc_reset_n && do_fill) begin
            tag_q[fill_idx][victim_c]  <= fill_tag;
            line_q[fill_idx][victim_c] <= bus.mem_rdata;
        end
    end

    assign bus.proc_stall = stall_c;
    assign bus.proc_rdata = rdata_c;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: two instances (2-way LRU with 8 sets and 16-bit counters,
// 4-way round-robin with 4 sets and 4-bit counters) share one stimulus stream;
// sel picks the instance being observed and modelled.
module tb_icache_assoc;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         proc_read = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic         proc_flush = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    logic [15:0] hit0, miss0;
    logic [3:0]  hit1, miss1;

    icache_assoc_if if0 ();
    icache_assoc_if if1 ();

    assign if0.proc_read  = proc_read;
    assign if0.proc_addr  = proc_addr;
    assign if0.proc_flush = proc_flush;
    assign if0.mem_rdata  = mem_rdata;
    assign if0.mem_ready  = mem_ready;
    assign if1.proc_read  = proc_read;
    assign if1.proc_addr  = proc_addr;
    assign if1.proc_flush = proc_flush;
    assign if1.mem_rdata  = mem_rdata;
    assign if1.mem_ready  = mem_ready;

    icache_assoc #(.SETS(8), .WAYS(2), .REPL(0), .CNT_W(16)) dut0 (
        .clk(clk), .proc_reset_n(rst_n), .bus(if0), .hit_cnt(hit0), .miss_cnt(miss0));
    icache_assoc #(.SETS(4), .WAYS(4), .REPL(1), .CNT_W(4)) dut1 (
        .clk(clk), .proc_reset_n(rst_n), .bus(if1), .hit_cnt(hit1), .miss_cnt(miss1));

    always #5 clk = ~clk;

    logic        stall_o, mem_read_o;
    logic [31:0] rdata_o;
    logic [27:0] mem_addr_o;
    logic [15:0] hit_o, miss_o;
    assign stall_o    = sel ? if1.proc_stall : if0.proc_stall;
    assign rdata_o    = sel ? if1.proc_rdata : if0.proc_rdata;
    assign mem_read_o = sel ? if1.mem_read   : if0.mem_read;
    assign mem_addr_o = sel ? if1.mem_addr   : if0.mem_addr;
    assign hit_o      = sel ? 16'(hit1)  : hit0;
    assign miss_o     = sel ? 16'(miss1) : miss0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line contents as a function of line address; line 0x4 is the canonical pattern.
    function automatic logic [127:0] mk_line(input logic [27:0] la);
        logic [31:0] x;
        x = (32'(la) - 32'd4) * 32'h9E37_79B9;
        return {32'hDDDD_DDDD ^ x, 32'hCCCC_CCCC ^ x, 32'hBBBB_BBBB ^ x, 32'hAAAA_AAAA ^ x};
    endfunction

    // Reference model: slots per set, last-use timestamps for LRU, fill count for round-robin.
    int unsigned  m_sets, m_ways, m_repl, m_cmax, m_hits, m_misses;
    bit           m_valid [8][4];
    int unsigned  m_tag   [8][4];
    logic [127:0] m_line  [8][4];
    longint       m_use   [8][4];
    int unsigned  m_fills [8];
    longint       m_time;

    task automatic mdl_flush();
        for (int s = 0; s < 8; s++) begin
            m_fills[s] = 0;
            for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic mdl_reset(input bit s);
        m_sets = s ? 4 : 8;
        m_ways = s ? 4 : 2;
        m_repl = s ? 1 : 0;
        m_cmax = s ? 15 : 65535;
        m_hits = 0;
        m_misses = 0;
        m_time = 0;
        mdl_flush();
    endtask

    function automatic int mdl_find(input logic [29:0] a);
        int unsigned la, s, t;
        la = 32'(a[29:2]);
        s = la % m_sets;
        t = la / m_sets;
        for (int w = 0; w < int'(m_ways); w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    task automatic mdl_touch(input int unsigned s, input int w);
        m_time++;
        m_use[s][w] = m_time;
    endtask

    task automatic mdl_fill(input logic [29:0] a);
        int unsigned la, s, t;
        int v;
        la = 32'(a[29:2]);
        s = la % m_sets;
        t = la / m_sets;
        v = -1;
        for (int w = 0; w < int'(m_ways); w++) if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) begin
            if (m_repl == 0) begin
                v = 0;
                for (int w = 1; w < int'(m_ways); w++) if (m_use[s][w] < m_use[s][v]) v = w;
            end else begin
                v = int'(m_fills[s] % m_ways);
            end
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v] = t;
        m_line[s][v] = mk_line(a[29:2]);
        m_fills[s]++;
        mdl_touch(s, v);
    endtask

    task automatic do_reset(input bit s);
        sel = s;
        rst_n = 1'b0;
        proc_read = 1'b1;
        proc_addr = '0;
        proc_flush = 1'b0;
        mem_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mem_read", mem_read_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_hit_cnt", hit_o, 0);
        chk("rst_miss_cnt", miss_o, 0);
        step();
        rst_n = 1'b1;
        proc_read = 1'b0;
        mdl_reset(s);
    endtask

    // One fetch, called just after a rising edge. Misses are served after lat extra
    // FETCH cycles; flush_mid raises proc_flush in the first FETCH cycle and returns
    // after the resulting flush cycle with proc_read still asserted.
    task automatic do_read(input logic [29:0] addr, input int lat, input bit flush_mid,
                           output bit got_hit, output logic [31:0] word_seen);
        int w;
        int unsigned s;
        logic [127:0] ln;
        got_hit = 1'b0;
        word_seen = '0;
        proc_read = 1'b1;
        proc_addr = addr;
        w = mdl_find(addr);
        s = 32'(addr[29:2]) % m_sets;
        @(negedge clk);
        got_hit = !stall_o;
        chk("lookup_stall", stall_o, (w < 0));
        if (w >= 0) begin
            ln = m_line[s][w];
            word_seen = rdata_o;
            chk("hit_data", rdata_o, ln[{addr[1:0], 5'd0} +: 32]);
            step();
            mdl_touch(s, w);
            if (m_hits < m_cmax) m_hits++;
        end else begin
            step();
            if (m_misses < m_cmax) m_misses++;
            @(negedge clk);
            chk("miss_mem_read", mem_read_o, 1);
            chk("miss_mem_addr", mem_addr_o, addr[29:2]);
            chk("fetch_stall", stall_o, 1);
            if (flush_mid) proc_flush = 1'b1;
            for (int i = 0; i < lat; i++) begin
                step();
                proc_flush = 1'b0;
                @(negedge clk);
                chk("fetch_wait_stall", stall_o, 1);
                chk("fetch_wait_mem_read", mem_read_o, 1);
            end
            mem_ready = 1'b1;
            mem_rdata = mk_line(addr[29:2]);
            step();
            mem_ready = 1'b0;
            proc_flush = 1'b0;
            mem_rdata = '0;
            mdl_fill(addr);
            if (flush_mid) begin
                @(negedge clk);
                chk("pend_flush_stall", stall_o, 1);
                chk("pend_flush_rdata", rdata_o, 0);
                chk("pend_flush_mem_read", mem_read_o, 0);
                step();
                mdl_flush();
                return;
            end
            @(negedge clk);
            ln = mk_line(addr[29:2]);
            word_seen = rdata_o;
            chk("fill_return_stall", stall_o, 0);
            chk("fill_return_data", rdata_o, ln[{addr[1:0], 5'd0} +: 32]);
            chk("fill_mem_read_low", mem_read_o, 0);
            w = mdl_find(addr);
            step();
            mdl_touch(s, w);
            if (m_hits < m_cmax) m_hits++;
        end
        proc_read = 1'b0;
    endtask

    task automatic rand_run(input int n, input int shift, input int tag_lo, input int tag_hi);
        bit got;
        logic [31:0] wd;
        logic [29:0] a;
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(9, 0);
            if (r == 0) begin
                proc_read = 1'($urandom_range(1, 0));
                proc_addr = 30'($urandom);
                proc_flush = 1'b1;
                @(negedge clk);
                chk("rand_flush_stall", stall_o, 1);
                chk("rand_flush_rdata", rdata_o, 0);
                step();
                proc_flush = 1'b0;
                proc_read = 1'b0;
                mdl_flush();
            end else if (r == 1) begin
                proc_read = 1'b0;
                mem_ready = 1'b1;
                mem_rdata = {4{$urandom}};
                @(negedge clk);
                chk("idle_stall", stall_o, 0);
                chk("idle_rdata", rdata_o, 0);
                step();
                mem_ready = 1'b0;
            end else begin
                a = 30'(($urandom_range(tag_hi, tag_lo) << shift) |
                        ($urandom_range(1, 0) << 2) | $urandom_range(3, 0));
                do_read(a, $urandom_range(3, 0), 1'b0, got, wd);
            end
        end
        chk("rand_hit_cnt", hit_o, m_hits);
        chk("rand_miss_cnt", miss_o, m_misses);
    endtask

    typedef struct {
        bit          dsel;
        logic [29:0] addr;
        bit          exp_hit;
    } vec_t;

    initial begin
        vec_t tbl [20];
        bit got;
        logic [31:0] wd;

        // 0-7: 2-way LRU, set 0 tags A=1,B=2,C=3 after a first fetch of 0x10.
        // 8-19: 4-way round-robin, set 0 tags 1..6.
        tbl = '{
            '{1'b0, 30'h010, 1'b0}, '{1'b0, 30'h012, 1'b1},
            '{1'b0, 30'h020, 1'b0}, '{1'b0, 30'h040, 1'b0},
            '{1'b0, 30'h021, 1'b1}, '{1'b0, 30'h060, 1'b0},
            '{1'b0, 30'h020, 1'b1}, '{1'b0, 30'h040, 1'b0},
            '{1'b1, 30'h010, 1'b0}, '{1'b1, 30'h020, 1'b0},
            '{1'b1, 30'h030, 1'b0}, '{1'b1, 30'h040, 1'b0},
            '{1'b1, 30'h050, 1'b0}, '{1'b1, 30'h020, 1'b1},
            '{1'b1, 30'h060, 1'b0}, '{1'b1, 30'h020, 1'b0},
            '{1'b1, 30'h030, 1'b0}, '{1'b1, 30'h050, 1'b1},
            '{1'b1, 30'h010, 1'b0}, '{1'b1, 30'h063, 1'b1}
        };

        for (int i = 0; i < 20; i++) begin
            if (i == 0 || i == 8) do_reset(tbl[i].dsel);
            do_read(tbl[i].addr, $urandom_range(2, 0), 1'b0, got, wd);
            chk($sformatf("tbl_hit[%0d]", i), got, tbl[i].exp_hit);
            if (i == 0) begin
                chk("first_word", wd, 32'hAAAA_AAAA);
                chk("first_miss_cnt", miss_o, 1);
                chk("first_hit_cnt", hit_o, 1);
            end
        end

        // 4-bit counters saturate.
        do_reset(1'b1);
        for (int i = 0; i < 21; i++) do_read(30'h014, 0, 1'b0, got, wd);
        chk("sat_hit_cnt", hit_o, 15);
        chk("sat_miss_cnt", miss_o, 1);

        // Flush arriving during a fill is deferred until the fill completes.
        do_reset(1'b0);
        do_read(30'h044, 1, 1'b0, got, wd);
        do_read(30'h008, 2, 1'b1, got, wd);
        do_read(30'h008, 1, 1'b0, got, wd);
        chk("refetch_after_flush_miss", got, 0);
        chk("refetch_word", wd, mk_line(28'h2) & 128'hFFFF_FFFF);
        do_read(30'h044, 0, 1'b0, got, wd);
        chk("old_line_flushed", got, 0);
        chk("flush_hit_cnt", hit_o, 3);
        chk("flush_miss_cnt", miss_o, 4);

        // Flush and read together in IDLE: flush first, read retried as a miss.
        do_read(30'h044, 0, 1'b0, got, wd);
        chk("cached_before_flush", got, 1);
        proc_read = 1'b1;
        proc_addr = 30'h044;
        proc_flush = 1'b1;
        @(negedge clk);
        chk("flush_read_stall", stall_o, 1);
        chk("flush_read_rdata", rdata_o, 0);
        step();
        proc_flush = 1'b0;
        mdl_flush();
        do_read(30'h044, 1, 1'b0, got, wd);
        chk("retry_after_flush", got, 0);

        // Reset in the middle of a fill.
        do_reset(1'b0);
        proc_read = 1'b1;
        proc_addr = 30'h0C8;
        step();
        @(negedge clk);
        chk("midfetch_mem_read", mem_read_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midfetch_rst_stall", stall_o, 0);
        chk("midfetch_rst_rdata", rdata_o, 0);
        step();
        rst_n = 1'b1;
        proc_read = 1'b0;
        @(negedge clk);
        chk("midfetch_mem_read_drop", mem_read_o, 0);
        mem_ready = 1'b1;
        mem_rdata = mk_line(28'h32);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_mem_read", mem_read_o, 0);
        chk("late_ready_hit_cnt", hit_o, 0);
        chk("late_ready_miss_cnt", miss_o, 0);
        step();
        mdl_reset(1'b0);
        do_read(30'h0C8, 0, 1'b0, got, wd);
        chk("no_line_after_reset", got, 0);

        // Randomised traffic against the model, both instances.
        do_reset(1'b0);
        rand_run(200, 5, 0, 3);
        do_reset(1'b1);
        rand_run(200, 4, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
